alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 8-bit ALU-plus-result-register block.
- Accepts (opcode, A, B) commands over a valid/ready interface and buffers them in a small FIFO.
- Drives one command at a time onto the ALU operand/select pins, holding them stable until the registered result appears.
- Returns result F, flags c/z/o and compare G/L/E as one response beat over a second valid/ready interface.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, 2..16.
- FIRST_BAD_OP, 11: lowest unimplemented opcode; opcodes FIRST_BAD_OP..15 are rejected.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  4  opcode: 0 add, 1 sub, 2 negate B, 3 and, 4 xor, 5 or, 6 ones-comp, 7 rot-R, 8 rot-L, 9 shr, 10 shl.
- cmd_a, cmd_b  in  8  operands.
- alu_a, alu_b  out  8  registered operands to ALU.
- alu_s3, alu_s2, alu_s1, alu_s0  out  1  registered opcode bits to ALU select.
- alu_f  in  8  ALU registered result.
- alu_c, alu_z, alu_o, alu_g, alu_l, alu_e  in  1  ALU combinational flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts.
- rsp_f  out  8  result.
- rsp_flags  out  6  {g,l,e,o,z,c}.
- rsp_err  out  1  opcode rejected.

Behaviour:
- Reset (rst=0 at clk edge):
  - FIFO emptied; FSM to IDLE.
  - alu_a, alu_b, alu_s* cleared to 0.
  - rsp_valid, rsp_f, rsp_flags, rsp_err cleared to 0.
  - Applies mid-operation; any in-flight command is dropped.
- FIFO:
  - cmd_ready = !full.
  - Push when cmd_valid & cmd_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop head.
    - Valid opcode: load alu_a/alu_b/alu_s*, go to ISSUE.
    - Opcode >= FIRST_BAD_OP: no ALU load; set rsp_err=1, rsp_f=0, rsp_flags=0; go to RESP.
  - ISSUE (1 cycle): operands stable. At the edge, latch c,z,o,g,l,e into rsp_flags. The ALU result register captures at the same edge. Go to CAPTURE.
  - CAPTURE (1 cycle): latch alu_f into rsp_f, rsp_err=0. Go to RESP.
  - RESP: rsp_valid=1; rsp_f, rsp_flags, rsp_err held stable.
    - rsp_ready & FIFO non-empty: pop and load the next command (same rules as IDLE); no IDLE bubble.
    - rsp_ready & FIFO empty: go to IDLE.
- Latency: a valid command at the FIFO head in IDLE produces rsp_valid 3 cycles later (load, ISSUE, CAPTURE).
  - Throughput: one op per 3 cycles.
  - Rejected op: rsp_valid 1 cycle after pop.
- alu_* outputs change only on a pop of a valid opcode. They keep their last value otherwise, including after rejected ops.
- rsp_valid never drops without rsp_ready (stall-safe).

Optional Feature:
- Macro: ALU_SEQ_CHAIN_EN.
- With the macro defined:
  - Extra input port cmd_chain (1 bit), stored per FIFO entry.
  - On pop with chain=1, alu_a is loaded from chain_reg instead of the stored A.
  - chain_reg updates to rsp_f on every non-error CAPTURE; it resets to 0.
  - Rejected ops do not update chain_reg.
- Without the macro: no port, no chain_reg; A always comes from the FIFO.

Decomposition:
- Package alu_seq_pkg holds:
  - Opcode localparams OP_ADD..OP_SHL.
  - FIRST_BAD_OP default.
  - State encoding IDLE/ISSUE/CAPTURE/RESP.
  - Flag bit indices for rsp_flags.
- One sub-module, alu_cmd_fifo: DEPTH-parameterised sync FIFO, width 20 (21 with chain).

Test Plan:
- Reset then single op: add A=8'h7F, B=8'h01 -> after 3 cycles rsp_f=8'h80, o=1, c=0, z=0, rsp_err=0.
- Back-to-back with rsp_ready held 1:
  - Sequence: sub 5-5, xor AA^55, shl 81.
  - Expected: rsp_f 00 (z=1), FF, 02; responses exactly 3 cycles apart.
- Backpressure:
  - Push 6 cmds with DEPTH=4 and rsp_ready=0 -> cmd_ready falls after 5 accepted (4 in FIFO, 1 held in RESP).
  - rsp_f stays stable while stalled.
  - Releasing rsp_ready drains all 5 in order.
- Bad opcode: op=4'hC -> rsp_valid after 1 cycle, rsp_err=1, rsp_f=0; alu_s* unchanged; the next valid op works normally.
- Mid-operation reset: assert rst=0 during ISSUE -> next cycle rsp_valid=0, cmd_ready=1, FIFO empty; no stale response appears after reset.
- ALU_SEQ_CHAIN_EN: add 3+4, then chained add B=1 -> rsp_f 07 then 08; chained op after reset uses A=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states, flag bit positions and the buffered command record.
// ALU_SEQ_CHAIN_EN adds a per-command chain bit to the record.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NEG = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;

    localparam int FIRST_BAD_OP_DEFAULT = 11;

    // Bit positions inside rsp_flags = {g,l,e,o,z,c}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_O = 2;
    localparam int FLAG_E = 3;
    localparam int FLAG_L = 4;
    localparam int FLAG_G = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } seq_state_e;

    typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
        logic       chain;
`endif
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // An opcode is issued only if the ALU implements it and it sits below the reject threshold.
    function automatic logic op_supported(input logic [3:0] op, input int first_bad);
        logic known;
        case (op)
            OP_ADD, OP_SUB, OP_NEG, OP_AND, OP_XOR, OP_OR,
            OP_NOT, OP_ROR, OP_ROL, OP_SHR, OP_SHL: known = 1'b1;
            default:                                known = 1'b0;
        endcase
        return known && (int'({28'd0, op}) < first_bad);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead command FIFO; head entry is always visible on rdata.
// Reset is synchronous, active-low.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: buffers commands, drives one at a time, returns one response beat.
// Optional ALU_SEQ_CHAIN_EN: per-command chain bit feeds the previous result back in as operand A.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FIRST_BAD_OP = FIRST_BAD_OP_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic       cmd_chain,
`endif
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_s3,
    output logic       alu_s2,
    output logic       alu_s1,
    output logic       alu_s0,
    input  logic [7:0] alu_f,
    input  logic       alu_c,
    input  logic       alu_z,
    input  logic       alu_o,
    input  logic       alu_g,
    input  logic       alu_l,
    input  logic       alu_e,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_f,
    output logic [5:0] rsp_flags,
    output logic       rsp_err
);

    seq_state_e state_q, state_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic [7:0] rsp_f_q, rsp_f_d;
    logic [5:0] rsp_flags_q, rsp_flags_d;
    logic       rsp_err_q, rsp_err_d;
`ifdef ALU_SEQ_CHAIN_EN
    logic [7:0] chain_q, chain_d;
`endif

    cmd_t wr_cmd;
    cmd_t head_cmd;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    assign wr_cmd.op = cmd_op;
    assign wr_cmd.a  = cmd_a;
    assign wr_cmd.b  = cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
    assign wr_cmd.chain = cmd_chain;
`endif

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_cmd),
        .pop   (pop),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_f_d     = rsp_f_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_CHAIN_EN
        chain_d     = chain_q;
`endif
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                pop = !fifo_empty;
            end
            ISSUE: begin
                rsp_flags_d[FLAG_C] = alu_c;
                rsp_flags_d[FLAG_Z] = alu_z;
                rsp_flags_d[FLAG_O] = alu_o;
                rsp_flags_d[FLAG_E] = alu_e;
                rsp_flags_d[FLAG_L] = alu_l;
                rsp_flags_d[FLAG_G] = alu_g;
                state_d             = CAPTURE;
            end
            CAPTURE: begin
                rsp_f_d   = alu_f;
                rsp_err_d = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
                chain_d   = alu_f;
`endif
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (fifo_empty) begin
                        state_d = IDLE;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pop from IDLE or straight out of RESP share the same load rules, so there is no bubble.
        if (pop) begin
            if (op_supported(head_cmd.op, FIRST_BAD_OP)) begin
                alu_a_d   = head_cmd.a;
`ifdef ALU_SEQ_CHAIN_EN
                if (head_cmd.chain) begin
                    alu_a_d = chain_q;
                end
`endif
                alu_b_d   = head_cmd.b;
                alu_sel_d = head_cmd.op;
                state_d   = ISSUE;
            end else begin
                rsp_err_d   = 1'b1;
                rsp_f_d     = 8'h00;
                rsp_flags_d = 6'h00;
                state_d     = RESP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_sel_q   <= 4'h0;
            rsp_f_q     <= 8'h00;
            rsp_flags_q <= 6'h00;
            rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q     <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_f_q     <= rsp_f_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q     <= chain_d;
`endif
        end
    end

    assign alu_a                          = alu_a_q;
    assign alu_b                          = alu_b_q;
    assign {alu_s3, alu_s2, alu_s1, alu_s0} = alu_sel_q;
    assign rsp_valid                      = (state_q == RESP);
    assign rsp_f                          = rsp_f_q;
    assign rsp_flags                      = rsp_flags_q;
    assign rsp_err                        = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU (registered F, combinational flags).
// Define ALU_SEQ_CHAIN_EN to also exercise operand chaining.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
    logic       cmd_chain;
`endif
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_s3, alu_s2, alu_s1, alu_s0;
    logic [7:0] alu_f;
    logic       alu_c, alu_z, alu_o, alu_g, alu_l, alu_e;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_f;
    logic [5:0] rsp_flags;
    logic       rsp_err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] f;
        logic [5:0] flags;
        logic       err;
        int         cyc;
    } rsp_rec_t;

    rsp_rec_t rq[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DEPTH        (4),
        .FIRST_BAD_OP (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain (cmd_chain),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s3    (alu_s3),
        .alu_s2    (alu_s2),
        .alu_s1    (alu_s1),
        .alu_s0    (alu_s0),
        .alu_f     (alu_f),
        .alu_c     (alu_c),
        .alu_z     (alu_z),
        .alu_o     (alu_o),
        .alu_g     (alu_g),
        .alu_l     (alu_l),
        .alu_e     (alu_e),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err)
    );

    // Behavioural ALU: the external block the sequencer drives.
    logic [7:0] m_f;
    logic       m_c;
    logic       m_o;
    logic [3:0] m_sel;
    assign m_sel = {alu_s3, alu_s2, alu_s1, alu_s0};

    always_comb begin
        m_f = 8'h00;
        m_c = 1'b0;
        m_o = 1'b0;
        case (m_sel)
            4'd0: begin
                {m_c, m_f} = {1'b0, alu_a} + {1'b0, alu_b};
                m_o = (alu_a[7] == alu_b[7]) && (m_f[7] != alu_a[7]);
            end
            4'd1: begin
                m_f = alu_a - alu_b;
                m_c = alu_a < alu_b;
                m_o = (alu_a[7] != alu_b[7]) && (m_f[7] != alu_a[7]);
            end
            4'd2: begin
                m_f = 8'h00 - alu_b;
                m_c = alu_b != 8'h00;
                m_o = alu_b == 8'h80;
            end
            4'd3:  m_f = alu_a & alu_b;
            4'd4:  m_f = alu_a ^ alu_b;
            4'd5:  m_f = alu_a | alu_b;
            4'd6:  m_f = ~alu_a;
            4'd7:  begin m_f = {alu_a[0], alu_a[7:1]}; m_c = alu_a[0]; end
            4'd8:  begin m_f = {alu_a[6:0], alu_a[7]}; m_c = alu_a[7]; end
            4'd9:  begin m_f = {1'b0, alu_a[7:1]};     m_c = alu_a[0]; end
            4'd10: begin m_f = {alu_a[6:0], 1'b0};     m_c = alu_a[7]; end
            default: m_f = 8'h00;
        endcase
    end

    assign alu_c = m_c;
    assign alu_z = (m_f == 8'h00);
    assign alu_o = m_o;
    assign alu_g = alu_a > alu_b;
    assign alu_l = alu_a < alu_b;
    assign alu_e = alu_a == alu_b;

    always @(posedge clk) alu_f <= m_f;
    always @(posedge clk) cyc <= cyc + 1;

    // Record each accepted response beat with the cycle index it was presented in.
    always @(posedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            rq.push_back('{rsp_f, rsp_flags, rsp_err, cyc});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic rsp_rec_t rec_at(input int k);
        rsp_rec_t r;
        r = '{8'h00, 6'h00, 1'b0, -1000};
        if (k < rq.size()) r = rq[k];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            output logic ok, output int pcyc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        ok        = 1'b0;
        pcyc      = -1;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (cmd_ready) begin
                ok   = 1'b1;
                pcyc = cyc + 1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int i;
        i = 0;
        while (rq.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check_eq("rsp_count", rq.size(), n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic      ok;
        int        p0, p1;
        int        accepted;
        rsp_rec_t  r;

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        rsp_ready = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        cmd_chain = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_alu_b", alu_b, 0);
        check_eq("rst_alu_s", m_sel, 0);
        check_eq("rst_rsp_f", rsp_f, 0);
        check_eq("rst_rsp_flags", rsp_flags, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single add 7F+01
        rsp_ready = 1'b1;
        rq.delete();
        push_cmd(4'd0, 8'h7F, 8'h01, ok, p0);
        check_eq("add_accept", ok, 1);
        wait_rsps(1, 20);
        r = rec_at(0);
        check_eq("add_f", r.f, 8'h80);
        check_eq("add_flags", r.flags, 6'b100100);
        check_eq("add_err", r.err, 0);
        check_eq("add_latency", r.cyc - p0, 3);
        check_eq("add_alu_a", alu_a, 8'h7F);
        check_eq("add_alu_b", alu_b, 8'h01);

        // Back-to-back sub, xor, shl
        rq.delete();
        push_cmd(4'd1, 8'h05, 8'h05, ok, p0);
        push_cmd(4'd4, 8'hAA, 8'h55, ok, p1);
        push_cmd(4'd10, 8'h81, 8'h00, ok, p1);
        wait_rsps(3, 40);
        r = rec_at(0);
        check_eq("b2b_sub_f", r.f, 8'h00);
        check_eq("b2b_sub_flags", r.flags, 6'b001010);
        check_eq("b2b_sub_latency", r.cyc - p0, 3);
        r = rec_at(1);
        check_eq("b2b_xor_f", r.f, 8'hFF);
        check_eq("b2b_xor_flags", r.flags, 6'b100000);
        check_eq("b2b_xor_gap", r.cyc - rec_at(0).cyc, 3);
        r = rec_at(2);
        check_eq("b2b_shl_f", r.f, 8'h02);
        check_eq("b2b_shl_flags", r.flags, 6'b100001);
        check_eq("b2b_shl_gap", r.cyc - rec_at(1).cyc, 3);

        // Backpressure: 5 of 6 commands accepted while the response is stalled
        rsp_ready = 1'b0;
        rq.delete();
        repeat (2) @(negedge clk);
        accepted = 0;
        for (int i = 1; i <= 6; i++) begin
            push_cmd(4'd0, 8'(i * 16), 8'(i), ok, p1);
            if (ok) accepted++;
        end
        check_eq("bp_accepted", accepted, 5);
        check_eq("bp_cmd_ready", cmd_ready, 0);
        check_eq("bp_rsp_valid", rsp_valid, 1);
        check_eq("bp_rsp_f_a", rsp_f, 8'h11);
        repeat (4) @(negedge clk);
        check_eq("bp_rsp_f_b", rsp_f, 8'h11);
        check_eq("bp_rsp_valid_b", rsp_valid, 1);
        rsp_ready = 1'b1;
        wait_rsps(5, 60);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("bp_drain_f%0d", k), rec_at(k).f, 8'(8'h11 * (k + 1)));
        end
        check_eq("bp_drain_flags0", rec_at(0).flags, 6'b100000);
        check_eq("bp_drain_gap", rec_at(4).cyc - rec_at(3).cyc, 3);

        // Rejected opcode between two valid ones
        rq.delete();
        @(negedge clk);
        push_cmd(4'd5, 8'h0F, 8'hF0, ok, p0);
        wait_rsps(1, 20);
        check_eq("or_f", rec_at(0).f, 8'hFF);
        check_eq("or_flags", rec_at(0).flags, 6'b010000);
        push_cmd(4'hC, 8'h12, 8'h34, ok, p0);
        wait_rsps(2, 20);
        r = rec_at(1);
        check_eq("bad_err", r.err, 1);
        check_eq("bad_f", r.f, 8'h00);
        check_eq("bad_flags", r.flags, 6'h00);
        check_eq("bad_latency", r.cyc - p0, 1);
        check_eq("bad_alu_s", m_sel, 4'd5);
        check_eq("bad_alu_a", alu_a, 8'h0F);
        push_cmd(4'd3, 8'hF0, 8'h3C, ok, p0);
        wait_rsps(3, 20);
        r = rec_at(2);
        check_eq("after_bad_f", r.f, 8'h30);
        check_eq("after_bad_err", r.err, 0);
        check_eq("after_bad_flags", r.flags, 6'b100000);

        // Reset while the first of two commands is in ISSUE
        rq.delete();
        @(negedge clk);
        push_cmd(4'd0, 8'h01, 8'h02, ok, p0);
        push_cmd(4'd0, 8'h03, 8'h04, ok, p1);
        check_eq("mid_issue_alu_a", alu_a, 8'h01);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        check_eq("mid_rst_cmd_ready", cmd_ready, 1);
        check_eq("mid_rst_alu_a", alu_a, 8'h00);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("mid_rst_no_stale", rq.size(), 0);
        check_eq("mid_rst_idle_valid", rsp_valid, 0);
        push_cmd(4'd0, 8'h02, 8'h03, ok, p0);
        wait_rsps(1, 20);
        check_eq("post_rst_f", rec_at(0).f, 8'h05);
        check_eq("post_rst_flags", rec_at(0).flags, 6'b010000);
        check_eq("post_rst_latency", rec_at(0).cyc - p0, 3);

`ifdef ALU_SEQ_CHAIN_EN
        // Chained operand A
        rq.delete();
        cmd_chain = 1'b0;
        push_cmd(4'd0, 8'h03, 8'h04, ok, p0);
        cmd_chain = 1'b1;
        push_cmd(4'd0, 8'h99, 8'h01, ok, p1);
        cmd_chain = 1'b0;
        wait_rsps(2, 30);
        check_eq("chain_first_f", rec_at(0).f, 8'h07);
        check_eq("chain_second_f", rec_at(1).f, 8'h08);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rq.delete();
        cmd_chain = 1'b1;
        push_cmd(4'd0, 8'h55, 8'h05, ok, p0);
        cmd_chain = 1'b0;
        wait_rsps(1, 20);
        check_eq("chain_after_rst_f", rec_at(0).f, 8'h05);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
